// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master: one command in, one bus transaction, one response out.
// Optional macro AXIL_MASTER_ALIGN_CHECK_EN rejects unaligned commands locally with SLVERR.
module axi_lite_master_cmd #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  misaligned;
    logic                  aw_done;
    logic                  w_done;

    // AW and AR share one address register; only one of them is ever valid.
    assign m_axi_awaddr = addr_reg;
    assign m_axi_araddr = addr_reg;
    assign m_axi_awprot = AXI_PROT;
    assign m_axi_arprot = AXI_PROT;

    always_comb begin
        misaligned = 1'b0;
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
        misaligned = (cmd_addr[1:0] != 2'b00);
`endif
    end

    // A channel counts as done once its valid has dropped or it handshakes this cycle.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            addr_reg      <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready   <= 1'b0;
                        addr_reg    <= cmd_addr;
                        m_axi_wdata <= cmd_wdata;
                        m_axi_wstrb <= cmd_wstrb;
                        if (misaligned) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_write <= cmd_write;
                            rsp_rdata <= '0;
                            rsp_resp  <= 2'b10;
                        end else if (cmd_write) begin
                            state         <= WADDR;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                        end else begin
                            state         <= RADDR;
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end
                WADDR: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        state        <= WRESP;
                        m_axi_bready <= 1'b1;
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        state        <= RSP;
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                    end
                end
                RADDR: begin
                    if (m_axi_arready) begin
                        state         <= RDATA;
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid) begin
                        state        <= RSP;
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Scoreboard bench for axi_lite_master_cmd: reference memory model, randomized slave timing.
// Honours AXIL_MASTER_ALIGN_CHECK_EN when expecting unaligned-command behaviour.
module tb_axi_lite_master_cmd;

    logic        clk = 1'b0;
    logic        m_axi_areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_lite_master_cmd #(.ADDR_WIDTH(32), .AXI_PROT(3'b000)) dut (
        .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    int n_cmp = 0;
    int n_bad = 0;

    rsp_t        exp_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] ar_q[$];
    logic [31:0] mmem [16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expected event did not occur (got none, required one)", name);
    endtask

    function automatic bit align_chk();
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Slave error map: addresses 0x30-0x3F answer SLVERR (bit3=0) or DECERR (bit3=1).
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return (a[5:4] == 2'b11) ? {1'b1, a[3]} : 2'b00;
    endfunction

    // ---------------- slave: per-channel delays, own memory ----------------
    int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          aw_have, w_have, ar_have, b_act, r_act, b_hs, r_hs;
    logic [31:0] cap_aw, cap_ar, cap_wd, last_araddr;
    logic [3:0]  cap_ws;
    logic [31:0] smem [int unsigned];
    int          b_count = 0, ar_hs_count = 0;

    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        last_araddr = '0;
        forever begin
            @(negedge clk);
            if (m_axi_areset) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                aw_have = 0; w_have = 0; ar_have = 0; b_act = 0; r_act = 0;
                b_hs = 0; r_hs = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_q.delete(); w_q.delete(); ar_q.delete();
            end else begin
                if (b_hs) begin m_axi_bvalid = 0; b_hs = 0; end
                if (r_hs) begin m_axi_rvalid = 0; r_hs = 0; end
                if (aw_have && w_have) begin
                    logic [31:0] word;
                    word = smem.exists(cap_aw >> 2) ? smem[cap_aw >> 2] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (cap_ws[i]) word[8*i +: 8] = cap_wd[8*i +: 8];
                    smem[cap_aw >> 2] = word;
                    aw_have = 0; w_have = 0; b_act = 1; b_cnt = b_dly;
                end
                if (ar_have) begin ar_have = 0; r_act = 1; r_cnt = r_dly; end
                if (b_act && !m_axi_bvalid) begin
                    if (b_cnt == 0) begin
                        m_axi_bvalid = 1; m_axi_bresp = resp_of(cap_aw); b_act = 0;
                    end else b_cnt--;
                end
                b_hs = m_axi_bvalid && m_axi_bready;
                if (b_hs) b_count++;
                if (r_act && !m_axi_rvalid) begin
                    if (r_cnt == 0) begin
                        m_axi_rvalid = 1;
                        m_axi_rdata  = smem.exists(cap_ar >> 2) ? smem[cap_ar >> 2] : 32'h0;
                        m_axi_rresp  = resp_of(cap_ar);
                        r_act = 0;
                    end else r_cnt--;
                end
                r_hs = m_axi_rvalid && m_axi_rready;
                m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
                if (m_axi_awvalid && !m_axi_awready) aw_cnt++;
                if (m_axi_awvalid && m_axi_awready) begin
                    aw_cnt = 0; aw_have = 1; cap_aw = m_axi_awaddr;
                    if (aw_q.size() == 0) fail_now("aw_unexpected");
                    else check("awaddr", 128'(m_axi_awaddr), 128'(aw_q.pop_front()));
                    check("awprot", 128'(m_axi_awprot), 128'(3'b000));
                end
                m_axi_wready = m_axi_wvalid && (w_cnt >= w_dly);
                if (m_axi_wvalid && !m_axi_wready) w_cnt++;
                if (m_axi_wvalid && m_axi_wready) begin
                    w_cnt = 0; w_have = 1; cap_wd = m_axi_wdata; cap_ws = m_axi_wstrb;
                    if (w_q.size() == 0) fail_now("w_unexpected");
                    else check("wstrb_wdata", 128'({m_axi_wstrb, m_axi_wdata}), 128'(w_q.pop_front()));
                end
                m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_dly);
                if (m_axi_arvalid && !m_axi_arready) ar_cnt++;
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_cnt = 0; ar_have = 1; cap_ar = m_axi_araddr; last_araddr = m_axi_araddr;
                    ar_hs_count++;
                    if (ar_q.size() == 0) fail_now("ar_unexpected");
                    else check("araddr", 128'(m_axi_araddr), 128'(ar_q.pop_front()));
                    check("arprot", 128'(m_axi_arprot), 128'(3'b000));
                end
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    bit          rsp_random = 0;
    int          rsp_hold = 0;
    int          n_rsp = 0, rsp_run = 0, last_rsp_run = 0;
    bit          pv = 0, pr = 0, pw = 0;
    logic [1:0]  presp;
    logic [31:0] prdata;
    rsp_t        mon_e;

    initial begin
        rsp_ready = 0;
        forever begin
            @(negedge clk);
            if (m_axi_areset) begin
                pv = 0; rsp_run = 0; rsp_ready = 0;
            end else begin
                if (pv && !pr)
                    check("rsp_stable", 128'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                          128'({1'b1, pw, presp, prdata}));
                if (rsp_valid && rsp_hold > 0) begin
                    rsp_ready = 0; rsp_hold--;
                end else rsp_ready = rsp_random ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rsp_valid) rsp_run++;
                if (rsp_valid && rsp_ready) begin
                    n_rsp++; last_rsp_run = rsp_run; rsp_run = 0;
                    if (exp_q.size() == 0) fail_now("rsp_unexpected");
                    else begin
                        mon_e = exp_q.pop_front();
                        check("rsp_write", 128'(rsp_write), 128'(mon_e.w));
                        check("rsp_rdata", 128'(rsp_rdata), 128'(mon_e.rdata));
                        check("rsp_resp", 128'(rsp_resp), 128'(mon_e.resp));
                    end
                end
                pv = rsp_valid; pr = rsp_ready; pw = rsp_write; presp = rsp_resp; prdata = rsp_rdata;
            end
        end
    end

    // ---------------- bus protocol watcher ----------------
    bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic [3:0]  p_wstrb;
    int          aw_run, w_run, ar_run, b_run;
    int          last_aw_len = 0, last_w_len = 0, last_ar_len = 0, last_b_len = 0;

    initial begin
        forever begin
            @(negedge clk); #1;
            if (m_axi_areset) begin
                p_awv = 0; p_wv = 0; p_arv = 0; aw_run = 0; w_run = 0; ar_run = 0; b_run = 0;
            end else begin
                check("aw_ar_exclusive", 128'((m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid), 128'(0));
                if (p_awv && !p_awr)
                    check("aw_hold", 128'({m_axi_awvalid, m_axi_awaddr}), 128'({1'b1, p_awaddr}));
                if (p_wv && !p_wr)
                    check("w_hold", 128'({m_axi_wvalid, m_axi_wstrb, m_axi_wdata}),
                          128'({1'b1, p_wstrb, p_wdata}));
                if (p_arv && !p_arr)
                    check("ar_hold", 128'({m_axi_arvalid, m_axi_araddr}), 128'({1'b1, p_araddr}));
                if (m_axi_awvalid) aw_run++; else if (aw_run > 0) begin last_aw_len = aw_run; aw_run = 0; end
                if (m_axi_wvalid)  w_run++;  else if (w_run > 0)  begin last_w_len = w_run; w_run = 0; end
                if (m_axi_arvalid) ar_run++; else if (ar_run > 0) begin last_ar_len = ar_run; ar_run = 0; end
                if (m_axi_bready)  b_run++;  else if (b_run > 0)  begin last_b_len = b_run; b_run = 0; end
                p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
                p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
                p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit track);
        rsp_t        e;
        int unsigned t;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        t = 0;
        while (!cmd_ready && t < 300) begin @(negedge clk); #2; t++; end
        if (!cmd_ready) begin
            fail_now("cmd_accept_timeout");
            cmd_valid = 0;
            return;
        end
        e.w = w;
        if (align_chk() && a[1:0] != 2'b00) begin
            e.rdata = '0; e.resp = 2'b10;
            if (track) exp_q.push_back(e);
        end else begin
            if (w) begin aw_q.push_back(a); w_q.push_back({s, d}); end
            else ar_q.push_back(a);
            if (track) begin
                e.resp = resp_of(a);
                if (w) begin
                    e.rdata = '0;
                    for (int i = 0; i < 4; i++)
                        if (s[i]) mmem[a[5:2]][8*i +: 8] = d[8*i +: 8];
                end else e.rdata = mmem[a[5:2]];
                exp_q.push_back(e);
            end
        end
        @(negedge clk); #2;
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while ((!cmd_ready || exp_q.size() != 0) && t < 500) begin @(negedge clk); #2; t++; end
        if (!cmd_ready || exp_q.size() != 0) fail_now("idle_timeout");
    endtask

    // Cycles from accept edge until rsp_valid is seen; also reports whether cmd_ready stayed low.
    task automatic measure(output int lat, output bit busy_ok);
        lat = 1; busy_ok = 1;
        while (!rsp_valid && lat < 100) begin
            if (cmd_ready) busy_ok = 0;
            @(negedge clk); #2; lat++;
        end
        if (cmd_ready) busy_ok = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int lat, b0, ar0, n0;
    bit busy_ok;

    initial begin
        for (int i = 0; i < 16; i++) mmem[i] = '0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        m_axi_areset = 1;
        repeat (3) @(negedge clk);
        #2;
        check("reset_handshakes", 128'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
              m_axi_bready, m_axi_rready, rsp_valid}), 128'(7'b1000000));
        check("reset_rsp", 128'({rsp_write, rsp_resp, rsp_rdata}), 128'(0));
        check("reset_regs", 128'({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}), 128'(0));
        m_axi_areset = 0;
        @(negedge clk); #2;

        // Zero-wait write: AW/W together, one-cycle bready, response 3 cycles after accept.
        b0 = b_count;
        issue(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 1);
        measure(lat, busy_ok);
        check("wr_latency", 128'(lat), 128'(3));
        check("wr_busy", 128'(busy_ok), 128'(1));
        wait_idle();
        check("wr_aw_len", 128'(last_aw_len), 128'(1));
        check("wr_w_len", 128'(last_w_len), 128'(1));
        check("wr_bready_len", 128'(last_b_len), 128'(1));
        check("wr_b_count", 128'(b_count - b0), 128'(1));

        // awready delayed 3 cycles, wready immediate.
        aw_dly = 3; b0 = b_count;
        issue(1'b1, 32'h10, 32'h1234_5678, 4'h5, 1);
        wait_idle();
        check("awdly_aw_len", 128'(last_aw_len), 128'(4));
        check("awdly_w_len", 128'(last_w_len), 128'(1));
        check("awdly_b_count", 128'(b_count - b0), 128'(1));
        aw_dly = 0;

        // Read with arready delayed 2 cycles.
        issue(1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 1);
        wait_idle();
        ar_dly = 2;
        issue(1'b0, 32'h04, 32'h0, 4'h0, 1);
        measure(lat, busy_ok);
        check("rd_latency", 128'(lat), 128'(5));
        check("rd_busy", 128'(busy_ok), 128'(1));
        check("rd_data_direct", 128'(rsp_rdata), 128'(32'hDEAD_BEEF));
        wait_idle();
        check("rd_ar_len", 128'(last_ar_len), 128'(3));
        ar_dly = 0;

        // SLVERR read with the consumer stalling 4 cycles.
        rsp_hold = 4; n0 = n_rsp;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 1);
        begin
            int unsigned t = 0;
            while (n_rsp == n0 && t < 100) begin @(negedge clk); #2; t++; end
        end
        if (n_rsp == n0) fail_now("stall_rsp_timeout");
        check("stall_cmd_ready_busy", 128'(cmd_ready), 128'(0));
        check("stall_rsp_cycles", 128'(last_rsp_run), 128'(5));
        @(negedge clk); #2;
        check("stall_cmd_ready_back", 128'(cmd_ready), 128'(1));
        wait_idle();

        // Reset during WADDR with awvalid held.
        aw_dly = 10;
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0);
        check("pre_reset_awvalid", 128'(m_axi_awvalid), 128'(1));
        m_axi_areset = 1;
        @(negedge clk); #2;
        check("midreset_outputs", 128'({m_axi_awvalid, m_axi_wvalid, cmd_ready, rsp_valid}),
              128'(4'b0010));
        m_axi_areset = 0;
        aw_dly = 0;
        @(negedge clk); #2;

        // Unaligned read.
        ar0 = ar_hs_count;
        issue(1'b0, 32'h06, 32'h0, 4'h0, 1);
        measure(lat, busy_ok);
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
        check("unaligned_latency", 128'(lat), 128'(1));
        wait_idle();
        check("unaligned_no_ar", 128'(ar_hs_count - ar0), 128'(0));
`else
        wait_idle();
        check("unaligned_ar_count", 128'(ar_hs_count - ar0), 128'(1));
        check("unaligned_araddr", 128'(last_araddr), 128'(32'h06));
`endif

        // Randomized traffic against the reference memory.
        rsp_random = 1;
        repeat (60) begin
            logic        w;
            logic [31:0] a, d;
            logic [3:0]  s;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15)) << 2;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) begin @(negedge clk); #2; end
            issue(w, a, d, s, 1);
        end
        wait_idle();
        repeat (3) begin @(negedge clk); #2; end
        check("aw_queue_drained", 128'(aw_q.size()), 128'(0));
        check("ar_queue_drained", 128'(ar_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_cmd.md
AXI_LITE_MASTER_CMD -- requirements
Module: axi_lite_master_cmd

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, AXI-Lite address width; data width is fixed at 32, strobe width at 4.
REQ-002 Parameter: AXI_PROT, 3'b000, constant value driven on m_axi_awprot and m_axi_arprot.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Ports (clock and reset first):
- m_axi_aclk  in  1  clock
- m_axi_areset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP
- m_axi_aw*: awaddr ADDR_WIDTH, awprot 3, awvalid out, awready in
- m_axi_w*: wdata 32, wstrb 4, wvalid out, wready in
- m_axi_b*: bresp 2 in, bvalid in, bready out
- m_axi_ar*: araddr ADDR_WIDTH, arprot 3, arvalid out, arready in
- m_axi_r*: rdata 32 in, rresp 2 in, rvalid in, rready out

Function
REQ-005 FSM states: IDLE, WADDR (AW/W in flight), WRESP, RADDR, RDATA, RSP.
REQ-006 cmd_ready is 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready at a rising edge, and all cmd_* fields are registered on that edge.
REQ-007 Accepted write: next cycle, state is WADDR with awvalid=1 and wvalid=1; no bus signal is driven combinationally from cmd_*.
REQ-008 In WADDR, awvalid and wvalid each deassert independently the cycle after their own ready is sampled high; the transition to WRESP occurs when both have handshaken, including same-cycle handshakes and handshakes in the first cycle.
REQ-009 In WRESP, bready=1; on bvalid, bresp is captured and the state goes to RSP; bready is 0 in every other state.
REQ-010 Accepted read: next cycle, state is RADDR with arvalid=1; on arready, go to RDATA with arvalid=0.
REQ-011 In RDATA, rready=1; on rvalid, rdata/rresp are captured and the state goes to RSP; rready is 0 in every other state.
REQ-012 In RSP, rsp_valid=1 and rsp_* are stable until rsp_ready; on rsp_ready, return to IDLE. A new command may be accepted the cycle after.
REQ-013 Once asserted, valid signals are held with stable address, data, and strobe until their handshake; no valid waits on a ready.
REQ-014 Only one transaction is outstanding at a time; AW/W and AR are never active simultaneously.
REQ-015 Minimum latency with zero-wait slave and rsp_ready tied high: write is accept -> rsp_valid in 3 cycles; read is accept -> rsp_valid in 3 cycles.
REQ-016 Response values of 2'b10 and 2'b11 are passed through unchanged; the block performs no retry.

Reset
REQ-017 While m_axi_areset=1 at a clock edge: state=IDLE, and all valid/ready outputs are 0 except cmd_ready=1; rsp_rdata=0, rsp_resp=0, rsp_write=0, and registered address/data/strobe=0.
REQ-018 Reset in any state, including mid-handshake, returns to IDLE on that edge; any in-flight bus transaction is abandoned and the system is responsible for resetting the slave together with this block.

Configuration
REQ-019 Macro AXIL_MASTER_ALIGN_CHECK_EN:
- Defined: an accepted command with cmd_addr[1:0] != 0 issues no bus transaction; the next cycle is RSP with rsp_resp=2'b10, rsp_rdata=0, and rsp_write=cmd_write.
- Undefined: no check is made; the address is passed through unaltered.

Verification
REQ-020 Write addr 0x10, data 0xA5A5_0001, strb 0xF, with a zero-wait slave -> AW and W handshake on the same edge; bready for 1 cycle; rsp_valid with resp 0 and rsp_write=1, 3 cycles after accept.
REQ-021 Write where awready is delayed 3 cycles and wready is immediate -> wvalid drops after 1 cycle while awvalid holds 0x10 for 4 cycles; exactly one B is consumed.
REQ-022 Read addr 0x04 with arready delayed 2 cycles and rvalid returning rdata 0xDEAD_BEEF, rresp 0 -> arvalid held 3 cycles; rsp_rdata=0xDEADBEEF; cmd_ready=0 throughout.
REQ-023 Read returning rresp 2'b10 with rsp_ready held low 4 cycles -> rsp_valid and data are stable for 4 cycles; cmd_ready returns 1 the cycle after rsp_ready.
REQ-024 Reset asserted while in WADDR with awvalid=1 -> next edge: awvalid=wvalid=0, cmd_ready=1, rsp_valid=0.
REQ-025 With AXIL_MASTER_ALIGN_CHECK_EN, read addr 0x06 -> arvalid never asserts; rsp_resp=2'b10 one cycle after accept. Without the macro -> araddr=0x06 is issued.
